vpg_reconfig_ctrl: RTL and testbench

Sequences a video-mode change for the pattern generator. It takes the mode-change pulse and mode number from the mode selector and waits for the current frame to finish. It then holds the timing generator in reset while the pixel PLL is reprogrammed and locks, and releases the timing generator with the new mode active. It sits between the mode selector and the PLL reconfiguration port / timing generator, and is the only block allowed to drive either.

---
 rtl/vpg_reconfig_ctrl_pkg.sv | 32 +++
 rtl/vpg_sync2.sv | 24 ++
 rtl/vpg_reconfig_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_vpg_reconfig_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpg_reconfig_ctrl_pkg.sv
// Shared types and helpers for the video-mode reconfiguration sequencer.
package vpg_reconfig_ctrl_pkg;

  typedef logic [3:0] mode_t;

  // Mode codes understood by the timing generator and the pixel PLL.
  localparam mode_t Mode640x480p60   = 4'd0;
  localparam mode_t Mode800x600p60   = 4'd1;
  localparam mode_t Mode1024x768p60  = 4'd2;
  localparam mode_t Mode1280x720p60  = 4'd3;
  localparam mode_t Mode1920x1080p60 = 4'd9;
  localparam mode_t MODE_MAX         = 4'd9;

  typedef enum logic [2:0] {
    StHalt,
    StIdle,
    StDrain,
    StHold,
    StReconfig,
    StLock,
    StRelease
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vpg_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
module vpg_sync2 (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/vpg_reconfig_ctrl.sv
// Sequences a video-mode change: drain frame, hold timing in reset, reprogram and
// lock the pixel PLL, then release timing in the new mode.
module vpg_reconfig_ctrl
  import vpg_reconfig_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_TIMEOUT  = 4_000_000,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT   = 1_000_000,
  parameter int unsigned LOCK_STABLE    = 8,
  parameter int unsigned RELEASE_CYCLES = 64,
  parameter int unsigned LOCK_RETRIES   = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       mode_change_i,
  input  logic [3:0] mode_in_i,
  input  logic       frame_end_i,
  input  logic       pll_busy_i,
  input  logic       pll_locked_i,
  output logic       pll_start_o,
  output logic [3:0] pll_cfg_sel_o,
  output logic       timing_rst_o,
  output logic [3:0] active_mode_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic       bad_mode_o
);

  localparam int unsigned CntMax =
      umax(umax(DRAIN_TIMEOUT, SETTLE_CYCLES), umax(LOCK_TIMEOUT, RELEASE_CYCLES));
  localparam int unsigned CW = cnt_width(CntMax);
  localparam int unsigned SW = cnt_width(LOCK_STABLE);
  localparam int unsigned RW = cnt_width(LOCK_RETRIES);

  // Loads are N-1 so that a wait of N cycles ends on the cycle the counter reads zero.
  localparam logic [CW-1:0] DrainLoad  = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] SettleLoad = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] LockLoad   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] RelLoad    = CW'(RELEASE_CYCLES - 1);
  localparam logic [SW-1:0] StabLast   = SW'(LOCK_STABLE - 1);
  localparam logic [RW-1:0] RetryMax   = RW'(LOCK_RETRIES);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          busy_seen_q, busy_seen_d;
  mode_t         pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  mode_t         target_q;
  mode_t         active_q;
  logic          fault_q, fault_d;
  logic          ready_q, timing_rst_q, pll_start_q, bad_mode_q;

  logic          locked_s;
  logic          req_valid, req_bad;
  mode_t         pend_eff;
  logic          pend_eff_vld;
  logic          new_seq, lock_to, lock_fail;

  vpg_sync2 u_lock_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (pll_locked_i),
    .q_o     (locked_s)
  );

  assign req_valid    = mode_change_i && (mode_in_i <= MODE_MAX);
  assign req_bad      = mode_change_i && (mode_in_i > MODE_MAX);
  // A request arriving this cycle counts as pending so IDLE/HALT react without a bubble.
  assign pend_eff     = req_valid ? mode_in_i : pend_q;
  assign pend_eff_vld = req_valid | pend_vld_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stab_d      = stab_q;
    retry_d     = retry_q;
    busy_seen_d = busy_seen_q;
    new_seq     = 1'b0;
    lock_to     = 1'b0;
    lock_fail   = 1'b0;

    case (state_q)
      StHalt: begin
        if (pend_eff_vld) begin
          state_d = StHold;
          new_seq = 1'b1;
        end
      end
      StIdle: begin
        if (pend_eff_vld) begin
          state_d = StDrain;
          cnt_d   = DrainLoad;
        end
      end
      StDrain: begin
        if (frame_end_i || cnt_q == '0) begin
          state_d = StHold;
          new_seq = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d     = StReconfig;
          cnt_d       = LockLoad;
          busy_seen_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StReconfig: begin
        if (pll_busy_i) busy_seen_d = 1'b1;
        if (cnt_q == '0) lock_to = 1'b1;
        else             cnt_d   = cnt_q - CW'(1);
        if (busy_seen_q && !pll_busy_i) begin
          state_d = StLock;
          stab_d  = '0;
        end
      end
      StLock: begin
        if (cnt_q == '0) lock_to = 1'b1;
        else             cnt_d   = cnt_q - CW'(1);
        stab_d = locked_s ? stab_q + SW'(1) : '0;
        if (locked_s && stab_q == StabLast) begin
          state_d = StRelease;
          cnt_d   = RelLoad;
          lock_to = 1'b0;
        end
      end
      StRelease: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = StHalt;
    endcase

    if (new_seq) begin
      cnt_d   = SettleLoad;
      retry_d = '0;
    end

    // Timeout retries keep the latched target; pending stays queued for later.
    if (lock_to) begin
      if (retry_q < RetryMax) begin
        retry_d = retry_q + RW'(1);
        state_d = StHold;
        cnt_d   = SettleLoad;
      end else begin
        state_d   = StHalt;
        lock_fail = 1'b1;
      end
    end

    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (req_valid) begin
      pend_d     = mode_in_i;
      pend_vld_d = 1'b1;
    end
    if (new_seq) pend_vld_d = 1'b0;

    fault_d = fault_q;
    if (req_valid || (state_q == StHalt && state_d != StHalt)) fault_d = 1'b0;
    if (lock_fail) fault_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StHalt;
      cnt_q        <= '0;
      stab_q       <= '0;
      retry_q      <= '0;
      busy_seen_q  <= 1'b0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      target_q     <= '0;
      active_q     <= '0;
      fault_q      <= 1'b0;
      ready_q      <= 1'b0;
      timing_rst_q <= 1'b1;
      pll_start_q  <= 1'b0;
      bad_mode_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stab_q       <= stab_d;
      retry_q      <= retry_d;
      busy_seen_q  <= busy_seen_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      fault_q      <= fault_d;
      if (new_seq) target_q <= pend_eff;
      if (state_d == StRelease && state_q != StRelease) active_q <= target_q;
      ready_q      <= (state_d == StIdle);
      timing_rst_q <= !(state_d inside {StIdle, StDrain});
      pll_start_q  <= (state_d == StReconfig) && (state_q != StReconfig);
      bad_mode_q   <= req_bad;
    end
  end

  assign pll_start_o   = pll_start_q;
  assign pll_cfg_sel_o = target_q;
  assign timing_rst_o  = timing_rst_q;
  assign active_mode_o = active_q;
  assign ready_o       = ready_q;
  assign fault_o       = fault_q;
  assign bad_mode_o    = bad_mode_q;

endmodule

// File: tb/tb_vpg_reconfig_ctrl.sv
// Directed self-checking bench for vpg_reconfig_ctrl with shortened timing parameters.
module tb_vpg_reconfig_ctrl;

  localparam int unsigned DrainTo = 50;
  localparam int unsigned Settle  = 4;
  localparam int unsigned LockTo  = 40;
  localparam int unsigned Stable  = 3;
  localparam int unsigned RelCyc  = 5;
  localparam int unsigned Retries = 1;

  localparam int WReady = 0;
  localparam int WStart = 1;
  localparam int WTrst  = 2;
  localparam int WFault = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_change = 1'b0;
  logic [3:0] mode_in = 4'd0;
  logic       frame_end = 1'b0;
  logic       pll_busy = 1'b0;
  logic       locked_model = 1'b0;
  logic       locked_man = 1'b0;
  logic       use_man = 1'b0;
  logic       lock_fail = 1'b0;
  logic       pll_locked;

  logic       pll_start, timing_rst, ready, fault, bad_mode;
  logic [3:0] cfg, active;

  assign pll_locked = use_man ? locked_man : locked_model;

  vpg_reconfig_ctrl #(
    .DRAIN_TIMEOUT  (DrainTo),
    .SETTLE_CYCLES  (Settle),
    .LOCK_TIMEOUT   (LockTo),
    .LOCK_STABLE    (Stable),
    .RELEASE_CYCLES (RelCyc),
    .LOCK_RETRIES   (Retries)
  ) dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .mode_change_i (mode_change),
    .mode_in_i     (mode_in),
    .frame_end_i   (frame_end),
    .pll_busy_i    (pll_busy),
    .pll_locked_i  (pll_locked),
    .pll_start_o   (pll_start),
    .pll_cfg_sel_o (cfg),
    .timing_rst_o  (timing_rst),
    .active_mode_o (active),
    .ready_o       (ready),
    .fault_o       (fault),
    .bad_mode_o    (bad_mode)
  );

  always #5 clk = ~clk;

  // PLL model: busy for three cycles shortly after start, lock a cycle after busy drops.
  int pcnt = 0;
  always @(posedge clk) begin
    if (pll_start) begin
      pcnt         <= 6;
      locked_model <= 1'b0;
    end else if (pcnt != 0) begin
      pcnt <= pcnt - 1;
    end
    pll_busy <= (pcnt >= 3 && pcnt <= 5);
    if (pcnt == 1 && !lock_fail) locked_model <= 1'b1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_start = 0;
  int         last_start = 0;
  int         prev_start = 0;
  logic [3:0] start_cfg [64];
  always @(negedge clk) begin
    if (pll_start) begin
      if (n_start < 64) start_cfg[n_start] <= cfg;
      n_start    <= n_start + 1;
      prev_start <= last_start;
      last_start <= cyc;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic request(input logic [3:0] m);
    mode_change = 1'b1;
    mode_in     = m;
    @(negedge clk);
    mode_change = 1'b0;
  endtask

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  task automatic wait_cond(input int sel, input int budget);
    logic hit;
    for (int i = 0; i < budget; i++) begin
      case (sel)
        WReady:  hit = ready;
        WStart:  hit = pll_start;
        WTrst:   hit = timing_rst;
        default: hit = fault;
      endcase
      if (hit) break;
      @(negedge clk);
    end
  endtask

  function automatic logic [12:0] out_vec();
    return {timing_rst, ready, pll_start, fault, bad_mode, cfg, active};
  endfunction

  localparam logic [12:0] ResetVec = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};

  int s0;
  int hold_c;
  int drain_c;

  initial begin
    @(negedge clk);
    step(2);
    check_eq("reset_outputs", out_vec(), ResetVec);
    rst = 1'b0;
    step(3);
    check_eq("halt_idle_outputs", out_vec(), ResetVec);

    // Power-up: HALT goes straight to HOLD.
    s0 = n_start;
    request(4'd3);
    hold_c = cyc;
    check_eq("pu_cfg", cfg, 4'd3);
    check_eq("pu_trst_hold", timing_rst, 1'b1);
    wait_cond(WReady, 100);
    check_eq("pu_ready", ready, 1'b1);
    check_eq("pu_active", active, 4'd3);
    check_eq("pu_trst_low", timing_rst, 1'b0);
    check_eq("pu_nstart", n_start - s0, 1);
    check_eq("pu_start_delay", last_start - hold_c, Settle);

    // Normal change with frame_end 10 cycles after the request.
    request(4'd5);
    check_eq("nc_drain_ready", ready, 1'b0);
    check_eq("nc_drain_trst", timing_rst, 1'b0);
    step(9);
    pulse_frame_end();
    hold_c = cyc;
    check_eq("nc_hold_trst", timing_rst, 1'b1);
    check_eq("nc_hold_cfg", cfg, 4'd5);
    check_eq("nc_hold_active_old", active, 4'd3);
    wait_cond(WReady, 100);
    check_eq("nc_ready", ready, 1'b1);
    check_eq("nc_active", active, 4'd5);
    check_eq("nc_start_delay", last_start - hold_c, Settle);

    // Drain timeout.
    request(4'd6);
    drain_c = cyc;
    wait_cond(WTrst, 80);
    check_eq("dt_hold_entry", cyc - drain_c, DrainTo);
    wait_cond(WReady, 100);
    check_eq("dt_active", active, 4'd6);

    // Collision: 6 then 7 during LOCK of the sequence for 5.
    s0 = n_start;
    request(4'd5);
    pulse_frame_end();
    wait_cond(WStart, 20);
    check_eq("col_start_seen", pll_start, 1'b1);
    step(8);
    request(4'd6);
    request(4'd7);
    check_eq("col_busy_ready", ready, 1'b0);
    wait_cond(WReady, 100);
    check_eq("col_first_active", active, 4'd5);
    step(1);
    check_eq("col_one_idle", ready, 1'b0);
    check_eq("col_cfg_kept", cfg, 4'd5);
    pulse_frame_end();
    check_eq("col_cfg_next", cfg, 4'd7);
    wait_cond(WReady, 100);
    check_eq("col_final_active", active, 4'd7);
    check_eq("col_nstart", n_start - s0, 2);
    check_eq("col_cfg0", start_cfg[s0], 4'd5);
    check_eq("col_cfg1", start_cfg[s0+1], 4'd7);

    // Lock failure: one retry then fault.
    lock_fail = 1'b1;
    s0 = n_start;
    request(4'd2);
    pulse_frame_end();
    wait_cond(WFault, 200);
    check_eq("lf_fault", fault, 1'b1);
    check_eq("lf_halt_trst", timing_rst, 1'b1);
    check_eq("lf_ready", ready, 1'b0);
    check_eq("lf_active", active, 4'd7);
    check_eq("lf_nstart", n_start - s0, 2);
    check_eq("lf_start_gap", last_start - prev_start, LockTo + Settle);
    lock_fail = 1'b0;
    request(4'd4);
    check_eq("lf_fault_clr", fault, 1'b0);
    check_eq("lf_halt_cfg", cfg, 4'd4);
    wait_cond(WReady, 100);
    check_eq("lf_recover_active", active, 4'd4);

    // Invalid mode code is dropped.
    request(4'd12);
    check_eq("bad_pulse", bad_mode, 1'b1);
    check_eq("bad_ready", ready, 1'b1);
    step(1);
    check_eq("bad_pulse_end", bad_mode, 1'b0);
    s0 = n_start;
    step(10);
    check_eq("bad_no_start", n_start - s0, 0);
    check_eq("bad_still_ready", ready, 1'b1);
    check_eq("bad_cfg", cfg, 4'd4);

    // Lock glitch restarts the stability count.
    use_man    = 1'b1;
    locked_man = 1'b0;
    request(4'd8);
    pulse_frame_end();
    wait_cond(WStart, 20);
    check_eq("gl_start_seen", pll_start, 1'b1);
    step(7);
    locked_man = 1'b1;
    step(2);
    locked_man = 1'b0;
    step(1);
    locked_man = 1'b1;
    step(4);
    check_eq("gl_not_yet", active, 4'd4);
    step(1);
    check_eq("gl_released", active, 4'd8);
    wait_cond(WReady, 100);
    check_eq("gl_ready", ready, 1'b1);
    use_man = 1'b0;

    // Asynchronous reset during RECONFIG.
    request(4'd1);
    pulse_frame_end();
    wait_cond(WStart, 20);
    check_eq("rr_start_seen", pll_start, 1'b1);
    #2 rst = 1'b1;
    #1 check_eq("rr_async_outputs", out_vec(), ResetVec);
    step(2);
    rst = 1'b0;
    s0 = n_start;
    step(20);
    check_eq("rr_no_restart", n_start - s0, 0);
    check_eq("rr_halt_outputs", out_vec(), ResetVec);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
